// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the picorv32-style two-master memory arbiter.
package rv_mem_pkg;

  localparam int MEM_WORDS_DEFAULT = 512;
  localparam int XLEN              = 32;
  localparam int STRB_W            = XLEN / 8;
  localparam int WORD_IDX_W        = XLEN - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_MRG  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } master_t;

  // True when a word index falls outside the RAM.
  function automatic logic word_out_of_range(input logic [WORD_IDX_W-1:0] word,
                                             input int unsigned           words);
    return {2'b00, word} >= XLEN'(words);
  endfunction

endpackage

// File: rtl/rv_byte_merge.sv
// Byte-lane merge of a new write word over the old RAM word, selected by strobes.
module rv_byte_merge
  import rv_mem_pkg::*;
(
  input  logic [XLEN-1:0]   old_word,
  input  logic [XLEN-1:0]   new_word,
  input  logic [STRB_W-1:0] strb,
  output logic [XLEN-1:0]   merged
);

  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_byte
    assign merged[gi*8 +: 8] = strb[gi] ? new_word[gi*8 +: 8] : old_word[gi*8 +: 8];
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between a CPU and a
// host port; writes are read-modify-write so byte strobes need no byte-enable RAM.
module rv_mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              m0_valid,
  input  logic              m0_instr,
  input  logic [XLEN-1:0]   m0_addr,
  input  logic [XLEN-1:0]   m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [XLEN-1:0]   m0_rdata,

  input  logic              m1_valid,
  input  logic [XLEN-1:0]   m1_addr,
  input  logic [XLEN-1:0]   m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [XLEN-1:0]   m1_rdata,

  output logic [AW-1:0]     ram_addr,
  output logic [XLEN-1:0]   ram_wdata,
  output logic              ram_we,
  input  logic [XLEN-1:0]   ram_rdata,

  output logic              busy,
  output logic              err
);

  state_t                  state_reg;
  state_t                  state_next;
  master_t                 gnt_reg;
  master_t                 pick;
  logic [AW-1:0]           addr_reg;
  logic [XLEN-1:0]         wdata_reg;
  logic [STRB_W-1:0]       wstrb_reg;
  logic [XLEN-1:0]         resp_reg;
  logic                    oor_reg;

  logic [WORD_IDX_W-1:0]   sel_word;
  logic [XLEN-1:0]         sel_wdata;
  logic [STRB_W-1:0]       sel_wstrb;
  logic                    sel_oor;
  logic                    take;
  logic [XLEN-1:0]         merged_word;

  // Byte offsets and the instruction-fetch flag do not affect a word RAM access.
  logic unused_inputs;
  assign unused_inputs = ^{m0_instr, m0_addr[1:0], m1_addr[1:0]};

  // gnt_reg doubles as "last granted": a tie goes to the other master.
  always_comb begin
    pick = gnt_reg;
    if (m0_valid && m1_valid) begin
      pick = (gnt_reg == GNT_M0) ? GNT_M1 : GNT_M0;
    end else if (m0_valid) begin
      pick = GNT_M0;
    end else if (m1_valid) begin
      pick = GNT_M1;
    end
  end

  assign sel_word  = (pick == GNT_M0) ? m0_addr[XLEN-1:2] : m1_addr[XLEN-1:2];
  assign sel_wdata = (pick == GNT_M0) ? m0_wdata : m1_wdata;
  assign sel_wstrb = (pick == GNT_M0) ? m0_wstrb : m1_wstrb;
  assign sel_oor   = word_out_of_range(sel_word, MEM_WORDS);

  always_comb begin
    state_next = state_reg;
    take       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          take       = 1'b1;
          state_next = sel_oor ? ST_RESP : ST_RD;
        end
      end
      ST_RD:   state_next = ST_MRG;
      ST_MRG:  state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  rv_byte_merge u_merge (
    .old_word (ram_rdata),
    .new_word (wdata_reg),
    .strb     (wstrb_reg),
    .merged   (merged_word)
  );

  // Outputs decode straight from state so reset removes ram_we without waiting for a clock.
  always_comb begin
    busy      = (state_reg != ST_IDLE);
    ram_we    = (state_reg == ST_MRG) && (wstrb_reg != '0);
    ram_wdata = ram_we ? merged_word : '0;
    m0_ready  = (state_reg == ST_RESP) && (gnt_reg == GNT_M0);
    m1_ready  = (state_reg == ST_RESP) && (gnt_reg == GNT_M1);
    m0_rdata  = m0_ready ? resp_reg : '0;
    m1_rdata  = m1_ready ? resp_reg : '0;
    err       = (state_reg == ST_RESP) && oor_reg;
  end

  assign ram_addr = addr_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      gnt_reg   <= GNT_M1;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      resp_reg  <= '0;
      oor_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (take) begin
        gnt_reg   <= pick;
        wdata_reg <= sel_wdata;
        wstrb_reg <= sel_wstrb;
        oor_reg   <= sel_oor;
        resp_reg  <= '0;
        // Out-of-range requests never touch the RAM, so ram_addr keeps its last value.
        if (!sel_oor) begin
          addr_reg <= sel_word[AW-1:0];
        end
      end
      if (state_reg == ST_MRG) begin
        resp_reg <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench: directed table, hand-written corner sequences, and a
// randomized run against a queue/arithmetic model of the arbiter.
module tb_rv_mem_arbiter;

  localparam int MEM_WORDS = 512;
  localparam int AW        = 9;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m0_instr, m0_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_we, busy, err;

  int vectors = 0;
  int miscompares = 0;
  int we_cnt = 0;

  always #5 clk = ~clk;

  rv_mem_arbiter #(.MEM_WORDS(MEM_WORDS), .AW(AW)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .busy(busy), .err(err)
  );

  // Synchronous RAM model with a bulk-load port for preloading.
  logic [31:0] mem      [MEM_WORDS];
  logic [31:0] init_mem [MEM_WORDS];
  logic [31:0] shadow   [MEM_WORDS];
  logic        pre_all = 1'b0;

  always @(posedge clk) begin
    if (pre_all) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_mem[i];
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (ram_we) we_cnt <= we_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic load_mem();
    pre_all = 1'b1;
    @(negedge clk);
    pre_all = 1'b0;
  endtask

  // Completion records of the last run_req, in completion order.
  int          res_n;
  int          res_m   [2];
  int          res_cyc [2];
  logic [31:0] res_rd  [2];
  logic        res_err [2];

  // Present up to two requests in the same IDLE cycle and collect completions,
  // holding each valid until its own ready. Called and returns at a negedge.
  task automatic run_req(input logic v0, input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1);
    int  n;
    int  guard;
    bit  pend0, pend1;
    guard = 0;
    while (busy && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk1("idle before request", busy, 1'b0);
    m0_valid = v0; m0_addr = a0; m0_wdata = d0; m0_wstrb = s0; m0_instr = 1'($urandom_range(0, 1));
    m1_valid = v1; m1_addr = a1; m1_wdata = d1; m1_wstrb = s1;
    pend0 = v0; pend1 = v1; res_n = 0; n = 0;
    while ((pend0 || pend1) && n < 30) begin
      @(negedge clk);
      n++;
      chk1("ready to both masters", m0_ready && m1_ready, 1'b0);
      chk1("m0 unrequested ready", m0_ready && !pend0, 1'b0);
      chk1("m1 unrequested ready", m1_ready && !pend1, 1'b0);
      if (!m0_ready) chk32("m0 rdata outside ready", m0_rdata, 32'h0);
      if (!m1_ready) chk32("m1 rdata outside ready", m1_rdata, 32'h0);
      if (!m0_ready && !m1_ready) chk1("err outside ready", err, 1'b0);
      if (m0_ready && pend0 && res_n < 2) begin
        res_m[res_n] = 0; res_cyc[res_n] = n; res_rd[res_n] = m0_rdata; res_err[res_n] = err;
        $display("txn m0 addr=%h wstrb=%h rdata=%h err=%0d cycle=%0d", m0_addr, m0_wstrb, m0_rdata, err, n);
        res_n++; pend0 = 1'b0; m0_valid = 1'b0;
      end else if (m1_ready && pend1 && res_n < 2) begin
        res_m[res_n] = 1; res_cyc[res_n] = n; res_rd[res_n] = m1_rdata; res_err[res_n] = err;
        $display("txn m1 addr=%h wstrb=%h rdata=%h err=%0d cycle=%0d", m1_addr, m1_wstrb, m1_rdata, err, n);
        res_n++; pend1 = 1'b0; m1_valid = 1'b0;
      end
    end
    if (pend0 || pend1) begin
      vectors++;
      miscompares++;
      $display("FAIL request timeout: got %0d completions expected %0d", res_n, int'(v0) + int'(v1));
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int unsigned w;
    case ($urandom_range(0, 9))
      0: begin
        a = $urandom;
        if (a[31:2] < 30'(MEM_WORDS)) a[31] = 1'b1;
      end
      1: a = 32'h800 | ($urandom & 32'h3);
      default: begin
        w = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, MEM_WORDS - 1);
        a = (w << 2) | ($urandom & 32'h3);
      end
    endcase
    return a;
  endfunction

  typedef struct {
    logic        m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int          we0;
    int          last_word;
    bit          last_m1;
    logic [31:0] ra [2];
    logic [31:0] rd [2];
    logic [3:0]  rs [2];
    logic        rv [2];
    int          order [2];
    int          nord;
    int          ecyc [2];
    logic [31:0] erd [2];
    logic        eerr [2];
    int          writes;

    tbl[0] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 3, 32'hDEAD_BEEF, 1'b0};
    tbl[1] = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'h5, 3, 32'hAABB_CCDD, 1'b0};
    tbl[2] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 3, 32'hAA22_CC44, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_0800, 32'h0,         4'h0, 1, 32'h0,         1'b1};
    tbl[4] = '{1'b1, 32'h0000_07FC, 32'h5566_7788, 4'hF, 3, 32'h0123_4567, 1'b0};
    tbl[5] = '{1'b1, 32'h0000_07FC, 32'h0,         4'h0, 3, 32'h5566_7788, 1'b0};
    tbl[6] = '{1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 4'hF, 1, 32'h0,         1'b1};
    tbl[7] = '{1'b0, 32'h0000_0013, 32'h9900_0000, 4'h8, 3, 32'hDEAD_BEEF, 1'b0};
    tbl[8] = '{1'b0, 32'h0000_0011, 32'h0,         4'h0, 3, 32'h99AD_BEEF, 1'b0};
    tbl[9] = '{1'b1, 32'h0000_0800, 32'hCAFE_F00D, 4'hF, 1, 32'h0,         1'b1};

    resetn = 1'b0;
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    for (int i = 0; i < MEM_WORDS; i++) init_mem[i] = 32'h1000_0000 + i;
    init_mem[4]   = 32'hDEAD_BEEF;
    init_mem[8]   = 32'hAABB_CCDD;
    init_mem[511] = 32'h0123_4567;
    repeat (3) @(negedge clk);
    load_mem();

    chk1("reset m0_ready", m0_ready, 1'b0);
    chk1("reset m1_ready", m1_ready, 1'b0);
    chk32("reset m0_rdata", m0_rdata, 32'h0);
    chk32("reset m1_rdata", m1_rdata, 32'h0);
    chk1("reset ram_we", ram_we, 1'b0);
    chk1("reset busy", busy, 1'b0);
    chk1("reset err", err, 1'b0);
    chk32("reset ram_addr", 32'(ram_addr), 32'h0);
    chk32("reset ram_wdata", ram_wdata, 32'h0);
    resetn = 1'b1;

    // First tie after reset goes to m0; m1 is served right after, then the next tie goes to m0 again.
    for (int r = 0; r < 2; r++) begin
      run_req(1'b1, 32'h10, 32'h0, 4'h0, 1'b1, 32'h20, 32'h0, 4'h0);
      chk32("tie completions", res_n, 2);
      chk32("tie first master", res_m[0], 0);
      chk32("tie first cycle", res_cyc[0], 3);
      chk32("tie first rdata", res_rd[0], 32'hDEAD_BEEF);
      chk32("tie second master", res_m[1], 1);
      chk32("tie second cycle", res_cyc[1], 7);
      chk32("tie second rdata", res_rd[1], 32'hAABB_CCDD);
    end

    last_word = 8;
    for (int i = 0; i < 10; i++) begin
      we0 = we_cnt;
      if (tbl[i].m == 1'b0)
        run_req(1'b1, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, 1'b0, 32'h0, 32'h0, 4'h0);
      else
        run_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb);
      chk32("table completions", res_n, 1);
      chk32("table master", res_m[0], int'(tbl[i].m));
      chk32("table latency", res_cyc[0], tbl[i].lat);
      chk32("table rdata", res_rd[0], tbl[i].rdata);
      chk1("table err", res_err[0], tbl[i].err);
      chk32("table ram writes", we_cnt - we0, (!tbl[i].err && tbl[i].wstrb != 4'h0) ? 1 : 0);
      if (!tbl[i].err) last_word = int'(tbl[i].addr[10:2]);
      @(negedge clk);
      chk1("table back to idle", busy, 1'b0);
      chk32("ram_addr held in idle", 32'(ram_addr), 32'(last_word));
    end
    chk32("merged word 8 in RAM", mem[8], 32'hAA22_CC44);
    chk32("word 511 in RAM", mem[511], 32'h5566_7788);

    // Reset asserted during the merge cycle of a write must cancel it immediately.
    m1_valid = 1'b1; m1_addr = 32'h190; m1_wdata = 32'hFFFF_FFFF; m1_wstrb = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk1("ram_we in merge cycle", ram_we, 1'b1);
    chk32("ram_wdata in merge cycle", ram_wdata, 32'hFFFF_FFFF);
    #1 resetn = 1'b0;
    m1_valid = 1'b0;
    #1;
    chk1("ram_we after async reset", ram_we, 1'b0);
    chk1("busy after async reset", busy, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk1("no m1_ready in reset", m1_ready, 1'b0);
      chk1("no m0_ready in reset", m0_ready, 1'b0);
      chk32("ram_addr in reset", 32'(ram_addr), 32'h0);
    end
    resetn = 1'b1;
    @(negedge clk);
    chk32("aborted write left word", mem[100], 32'h1000_0064);
    chk1("idle after reset release", busy, 1'b0);

    run_req(1'b1, 32'h190, 32'h0, 4'h0, 1'b1, 32'h10, 32'h0, 4'h0);
    chk32("post-reset tie first master", res_m[0], 0);
    chk32("post-reset tie first rdata", res_rd[0], 32'h1000_0064);
    chk32("post-reset tie second cycle", res_cyc[1], 7);
    chk32("post-reset tie second rdata", res_rd[1], 32'h99AD_BEEF);
    last_m1 = 1'b1;

    for (int i = 0; i < MEM_WORDS; i++) begin
      init_mem[i] = $urandom;
      shadow[i]   = init_mem[i];
    end
    load_mem();

    for (int t = 0; t < 150; t++) begin
      for (int m = 0; m < 2; m++) begin
        rv[m] = ($urandom_range(0, 3) != 0);
        ra[m] = rand_addr();
        rd[m] = $urandom;
        rs[m] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      end
      if (!rv[0] && !rv[1]) rv[$urandom_range(0, 1)] = 1'b1;
      if (rv[0] && rv[1]) begin
        order[0] = last_m1 ? 0 : 1;
        order[1] = 1 - order[0];
        nord = 2;
      end else begin
        order[0] = rv[1] ? 1 : 0;
        nord = 1;
      end
      writes = 0;
      for (int k = 0; k < nord; k++) begin
        int   mm;
        int   lat;
        int   w;
        logic oor;
        mm  = order[k];
        oor = (ra[mm][31:2] >= 30'(MEM_WORDS));
        lat = oor ? 1 : 3;
        ecyc[k] = (k == 0) ? lat : ecyc[0] + 1 + lat;
        eerr[k] = oor;
        if (oor) begin
          erd[k] = 32'h0;
        end else begin
          w = int'(ra[mm][31:2]);
          erd[k] = shadow[w];
          if (rs[mm] != 4'h0) begin
            for (int b = 0; b < 4; b++)
              if (rs[mm][b]) shadow[w][8*b +: 8] = rd[mm][8*b +: 8];
            writes++;
          end
        end
        last_m1 = (mm == 1);
      end
      we0 = we_cnt;
      run_req(rv[0], ra[0], rd[0], rs[0], rv[1], ra[1], rd[1], rs[1]);
      chk32("rand completions", res_n, nord);
      for (int k = 0; k < nord; k++) begin
        chk32("rand master order", res_m[k], order[k]);
        chk32("rand ready cycle", res_cyc[k], ecyc[k]);
        chk32("rand rdata", res_rd[k], erd[k]);
        chk1("rand err", res_err[k], eerr[k]);
      end
      chk32("rand ram writes", we_cnt - we0, writes);
    end

    @(negedge clk);
    for (int i = 0; i < MEM_WORDS; i++) chk32("final RAM contents", mem[i], shadow[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv_mem_arbiter.md
RV_MEM_ARBITER -- requirements
Module: rv_mem_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 512: words in the shared single-port RAM.
REQ-002 Parameter AW, default 9: RAM word-address width, equal to clog2(MEM_WORDS).
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 resetn  in  1  reset; asynchronous, active-low.
REQ-005 m0_valid, m0_instr  in  1 each  CPU request (picorv32 native bus); held until m0_ready.
REQ-006 m0_addr, m0_wdata  in  32 each  CPU byte address and write data.
REQ-007 m0_wstrb  in  4  CPU byte strobes; 0 means read.
REQ-008 m0_ready  out  1  one-cycle completion pulse to the CPU.
REQ-009 m0_rdata  out  32  CPU read data, valid with m0_ready.
REQ-010 m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata  same widths and directions as m0_*  host/loader port; has no instr input.
REQ-011 ram_addr  out  AW  RAM word address.
REQ-012 ram_wdata  out  32  merged write word.
REQ-013 ram_we  out  1  RAM write enable.
REQ-014 ram_rdata  in  32  synchronous RAM read data, valid one cycle after ram_addr.
REQ-015 busy  out  1  high whenever the FSM is not in IDLE.
REQ-016 err  out  1  one-cycle pulse marking an out-of-range access.

Function
REQ-017 The FSM SHALL have four states: IDLE, RD, MRG and RESP.
REQ-018 IDLE SHALL grant on any valid, latch the granted master's addr[AW+1:2], wdata and wstrb, then go to RD; if addr[31:2] >= MEM_WORDS it SHALL go directly to RESP.
REQ-019 Arbitration SHALL be round-robin: with both valid, grant the master not granted last; a single valid requester always wins.
REQ-020 RD SHALL drive ram_addr from the latched address and go to MRG.
REQ-021 MRG with wstrb == 0 SHALL capture ram_rdata into the response register, with ram_we = 0.
REQ-022 MRG with wstrb != 0 SHALL assert ram_we for exactly one cycle, drive ram_wdata per byte (wstrb[i] ? wdata byte i : ram_rdata byte i), and return the old word as response data.
REQ-023 MRG SHALL always go to RESP.
REQ-024 RESP SHALL pulse the granted master's ready for one cycle with its rdata, then go to IDLE; the ungranted ready SHALL stay 0.
REQ-025 Latency SHALL be: valid seen in IDLE at cycle 0, ready at cycle 3 for both reads and writes.
REQ-026 Out-of-range accesses SHALL complete with ready at cycle 1, rdata = 0, no RAM write and err pulsed with ready.
REQ-027 ramp rdata for the ungranted master and all rdata outside RESP SHALL be 0.
REQ-028 A request arriving while busy SHALL wait; the arbiter SHALL add no back-to-back gap beyond returning to IDLE.
REQ-029 A valid deasserted mid-transaction SHALL be ignored; the transaction completes and the write, if any, still occurs.
REQ-030 ram_addr SHALL hold its last value while in IDLE.

Reset
REQ-031 Reset SHALL place the FSM in IDLE and the last-grant register at m1, so m0 wins the first tie.
REQ-032 Reset SHALL clear m0_ready, m1_ready, m0_rdata, m1_rdata, ram_we, busy, err, ram_addr and ram_wdata to 0.
REQ-033 ram_we SHALL decode from state, so a reset asserted in MRG deasserts ram_we immediately.

Structure
REQ-034 Package rv_mem_pkg SHALL hold the state enum, the MEM_WORDS default and the bus-width constants.
REQ-035 Sub-module rv_byte_merge SHALL implement the combinational strobe merge.

Verification
REQ-036 m0 reads word 4 (addr 0x10) preloaded with 0xDEADBEEF -> m0_ready at cycle 3, m0_rdata = 0xDEADBEEF, ram_we never high.
REQ-037 m1 writes 0x11223344 with wstrb 4'b0101 to a word holding 0xAABBCCDD -> RAM word = 0xAA22CC44, m1_ready at cycle 3.
REQ-038 m0 and m1 both valid after reset -> m0 served first, then m1 starts in the cycle after m0_ready; the second tie goes to m0.
REQ-039 m0 reads addr 0x800 with MEM_WORDS = 512 -> m0_ready and err at cycle 1, rdata = 0, no ram_we.
REQ-040 resetn low during MRG of a write -> ram_we drops asynchronously, FSM in IDLE, no ready pulse.
